cache_mem_if: RTL

Memory-side interface stage sitting directly downstream of the 2-way cache. Services cache line refills by issuing two byte reads to main memory and returning the assembled 16-bit line. Forwards write-through stores from the cache to main memory via a small posted write buffer. All main-memory traffic uses one byte-wide req/ack port.

---
 rtl/cache_mem_if_pkg.sv | 25 ++
 rtl/cache_mem_if_if.sv | 32 +++
 rtl/cache_mem_if_wbuf.sv | 65 ++++++
 rtl/cache_mem_if.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cache_mem_if_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and widths for the cache memory-side interface stage.
//   state_t     : refill / write-drain FSM states
//   LINE_W      : refill line width (two bytes)
//   BYTE_W      : main-memory data width
//   ADDR_W      : main-memory byte address width
//   LINE_ADDR_W : line address width (byte address [15:1])
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_W      = 16;
    localparam int BYTE_W      = 8;
    localparam int ADDR_W      = 16;
    localparam int LINE_ADDR_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_DONE  = 3'd3,
        ST_WR    = 3'd4
    } state_t;

endpackage

// File: rtl/cache_mem_if_if.sv
// -----------------------------------------------------------------------------
// cache_mem_if_if
// Byte-wide req/ack bus to main memory.
//   mem_req   : request (held until the ack cycle)
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : byte address
//   mem_wdata : write byte
//   mem_rdata : read byte, valid with mem_ack
//   mem_ack   : one-cycle completion
// master = the interface stage, slave = main memory.
// -----------------------------------------------------------------------------
interface cache_mem_if_if;
    import cache_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_wdata;
    logic [BYTE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/cache_mem_if_wbuf.sv
// -----------------------------------------------------------------------------
// cache_wbuf
// Posted store FIFO (address + byte). DEPTH must be a power of 2, >= 2, so the
// read/write pointers wrap naturally.
//   clk, rst_n          : clock, synchronous active-low reset (empties FIFO)
//   i_push, i_addr/data : enqueue (ignored when full)
//   i_pop               : dequeue head (ignored when empty)
//   o_full, o_empty     : occupancy flags
//   o_head_addr/data    : oldest entry
// -----------------------------------------------------------------------------
module cache_wbuf
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [BYTE_W-1:0] o_head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [BYTE_W-1:0] r_data [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic              w_push;
    logic              w_pop;

    assign o_full      = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_addr = r_addr[r_rp];
    assign o_head_data = r_data[r_rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wp] <= i_addr;
            r_data[r_wp] <= i_data;
        end
    end

endmodule

// File: rtl/cache_mem_if.sv
// -----------------------------------------------------------------------------
// cache_mem_if
// Memory-side stage below the 2-way cache. Refills a 16-bit line with two byte
// reads and forwards write-through stores to main memory over one byte bus.
//   clk, rst_n        : clock, synchronous active-low reset
//   fill_req/addr     : refill request (held until fill_valid) and line address
//   fill_data/valid   : assembled line, one-cycle valid pulse
//   wr_req/addr/data  : store request; accepted when wr_req && wr_ready
//   wr_ready          : store can be accepted
//   busy              : FSM active (or posted stores pending)
//   mem               : main-memory bus (master side)
// Build option: define CACHE_WBUF_EN for a WBUF_DEPTH-entry posted write
// buffer; without it a store goes straight to the memory registers.
// -----------------------------------------------------------------------------
module cache_mem_if
    import cache_pkg::*;
#(
    parameter int WBUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fill_req,
    input  logic [LINE_ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0]      fill_data,
    output logic                   fill_valid,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [BYTE_W-1:0]      wr_data,
    output logic                   wr_ready,
    output logic                   busy,
    cache_mem_if_if.master         mem
);

    state_t            r_state, w_state_nxt;
    logic              r_mem_req,   w_mem_req_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [BYTE_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [LINE_W-1:0] r_fill_data;

    logic              w_ack;      // ack qualified by an outstanding request
    logic              w_accept;   // store handshake this cycle
    logic              w_wr_pend;  // a store is ready to go to memory
    logic [ADDR_W-1:0] w_wr_addr;
    logic [BYTE_W-1:0] w_wr_data;

    assign w_ack    = mem.mem_ack && r_mem_req;
    assign w_accept = wr_req && wr_ready;

`ifdef CACHE_WBUF_EN
    logic              w_full, w_empty, w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [BYTE_W-1:0] w_head_data;

    assign w_pop = (r_state == ST_WR) && w_ack;

    cache_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept),
        .i_addr      (wr_addr),
        .i_data      (wr_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    // Refill pending blocks new stores so they cannot starve it.
    assign wr_ready = !w_full && !fill_req;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    // A store pushed into an empty buffer is also the head: bypass it so the
    // write request goes out on the very next cycle.
    assign w_wr_pend = !w_empty || w_accept;
    assign w_wr_addr = w_empty ? wr_addr : w_head_addr;
    assign w_wr_data = w_empty ? wr_data : w_head_data;
`else
    assign wr_ready  = (r_state == ST_IDLE) && !fill_req;
    assign busy      = (r_state != ST_IDLE);
    assign w_wr_pend = w_accept;
    assign w_wr_addr = wr_addr;
    assign w_wr_data = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state plus next values of the registered memory outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            ST_IDLE: begin
                w_mem_req_nxt = 1'b0;
                // Stores first: a refill must see every earlier store.
                if (w_wr_pend) begin
                    w_state_nxt     = ST_WR;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = w_wr_addr;
                    w_mem_wdata_nxt = w_wr_data;
                end else if (fill_req) begin
                    w_state_nxt    = ST_RD_LO;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = {fill_addr, 1'b0};
                end
            end
            ST_RD_LO: begin
                // Request stays up; only the address steps to the high byte.
                if (w_ack) begin
                    w_state_nxt    = ST_RD_HI;
                    w_mem_addr_nxt = {fill_addr, 1'b1};
                end
            end
            ST_RD_HI: begin
                if (w_ack) begin
                    w_state_nxt   = ST_DONE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_WR: begin
                if (w_ack) begin
                    w_state_nxt   = ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fill_data <= '0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (r_state == ST_RD_LO && w_ack) r_fill_data[7:0]  <= mem.mem_rdata;
            if (r_state == ST_RD_HI && w_ack) r_fill_data[15:8] <= mem.mem_rdata;
        end
    end

    assign fill_data     = r_fill_data;
    assign fill_valid    = (r_state == ST_DONE);
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

endmodule
